// File: rtl/digit_cmp_pkg.sv
// Shared types and helpers for the digit-serial compare-exchange cell.
package digit_cmp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEqual,
    StDecided
  } cmp_state_e;

  function automatic int unsigned cnt_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/digit_cmp_fsm.sv
// Digit counter, per-word compare FSM and swap latch; sw_o is valid for the current digit.
// Optional macro CMP_SIGNED_EN: compare the MSB digit as two's complement (signed words).
module digit_cmp_fsm
  import digit_cmp_pkg::*;
#(
  parameter int unsigned DIGIT_W     = 1,
  parameter int unsigned WORD_DIGITS = 8,
  parameter int unsigned DESCEND     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] a_digit_i,
  input  logic [DIGIT_W-1:0] b_digit_i,
  input  logic               run_i,
  output logic               sw_o,
  output logic               last_o
);

  localparam int unsigned     CntW    = cnt_width(WORD_DIGITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(WORD_DIGITS - 1);
  localparam logic            Desc    = (DESCEND != 0);

  cmp_state_e      state_q;
  logic            sw_q;
  logic [CntW-1:0] cnt_q;

  logic diff, a_gt_b, sw_new, last_digit;

  always_comb begin
    diff = (a_digit_i != b_digit_i);
`ifdef CMP_SIGNED_EN
    if (cnt_q == '0) begin
      a_gt_b = ($signed(a_digit_i) > $signed(b_digit_i));
    end else begin
      a_gt_b = (a_digit_i > b_digit_i);
    end
`else
    a_gt_b = (a_digit_i > b_digit_i);
`endif
    last_digit = (cnt_q == LastCnt);
    // Once decided, later digits cannot change the steering of this word.
    if (state_q == StDecided) begin
      sw_new = sw_q;
    end else begin
      sw_new = diff & (a_gt_b ^ Desc);
    end
    sw_o   = run_i & sw_new;
    last_o = run_i & last_digit;
  end

  always_ff @(posedge clk) begin
    if (rst || !run_i) begin
      state_q <= StIdle;
      sw_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (last_digit) begin
      state_q <= StEqual;
      sw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= ((state_q == StDecided) || diff) ? StDecided : StEqual;
      sw_q    <= sw_new;
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/digit_cmp_swap.sv
// Digit-serial compare-exchange cell: two-stage pipeline around the compare FSM.
// Optional macro CMP_SIGNED_EN (handled in digit_cmp_fsm): signed word ordering.
module digit_cmp_swap
  import digit_cmp_pkg::*;
#(
  parameter int unsigned DIGIT_W     = 1,
  parameter int unsigned WORD_DIGITS = 8,
  parameter int unsigned DESCEND     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] a_digit_i,
  input  logic [DIGIT_W-1:0] b_digit_i,
  input  logic               run_i,
  input  logic               swap_i,
  output logic [DIGIT_W-1:0] lo_digit_o,
  output logic [DIGIT_W-1:0] hi_digit_o,
  output logic               swap_o,
  output logic               run_o,
  output logic               last_o
);

  logic sw, last;

  // Stage 1: captured digit plus its steering decision.
  logic [DIGIT_W-1:0] a_q, b_q;
  logic               run1_q, swap1_q, sw1_q, last1_q;
  // Stage 2: registered outputs.
  logic [DIGIT_W-1:0] lo_q, hi_q, lo_d, hi_d;
  logic               swap2_q, run2_q, last2_q, swap_d;

  digit_cmp_fsm #(
    .DIGIT_W    (DIGIT_W),
    .WORD_DIGITS(WORD_DIGITS),
    .DESCEND    (DESCEND)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .a_digit_i(a_digit_i),
    .b_digit_i(b_digit_i),
    .run_i    (run_i),
    .sw_o     (sw),
    .last_o   (last)
  );

  always_comb begin
    lo_d   = '0;
    hi_d   = '0;
    swap_d = run1_q & (swap1_q | sw1_q);
    if (run1_q) begin
      if (sw1_q) begin
        lo_d = b_q;
        hi_d = a_q;
      end else begin
        lo_d = a_q;
        hi_d = b_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      run1_q  <= 1'b0;
      swap1_q <= 1'b0;
      sw1_q   <= 1'b0;
      last1_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      swap2_q <= 1'b0;
      run2_q  <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      a_q     <= a_digit_i;
      b_q     <= b_digit_i;
      run1_q  <= run_i;
      swap1_q <= swap_i;
      sw1_q   <= sw;
      last1_q <= last;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      swap2_q <= swap_d;
      run2_q  <= run1_q;
      last2_q <= last1_q;
    end
  end

  assign lo_digit_o = lo_q;
  assign hi_digit_o = hi_q;
  assign swap_o     = swap2_q;
  assign run_o      = run2_q;
  assign last_o     = last2_q;

endmodule

// File: doc/digit_cmp_swap.md
Name: digit_cmp_swap

Overview:
- Parametrised digit-serial compare-exchange cell for the bubble-sort network.
- Takes two operand streams, MSB digit first, DIGIT_W bits per cycle, WORD_DIGITS digits per word.
- Emits the smaller (lo) and larger (hi) stream, or the reverse when descending, plus a swap flag and a run flag for chaining to the next cell.
- Adds multi-bit digits, a word-length counter for back-to-back words, sort direction and reset.

Parameters:
DIGIT_W, 1, bits per digit (>=1)
WORD_DIGITS, 8, digits per word (>=2)
DESCEND, 0, 0 = lo_digit_o carries smaller word; 1 = lo_digit_o carries larger word

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
a_digit_i  in  DIGIT_W  operand A digit, MSB digit first
b_digit_i  in  DIGIT_W  operand B digit
run_i  in  1  high while digits are valid; words are contiguous while high
swap_i  in  1  swap flag from the upstream cell, digit-aligned with the operands
lo_digit_o  out  DIGIT_W  steered low stream
hi_digit_o  out  DIGIT_W  steered high stream
swap_o  out  1  swap_i delayed, ORed with the current word's swap decision
run_o  out  1  run_i delayed 2
last_o  out  1  high on the output cycle of the final digit of each word

Behaviour:
- Reset: one clock, synchronous, active-high. rst=1 at a rising edge clears all registers, the digit counter and the FSM (to IDLE) on that edge. All outputs are 0 from that edge.
- Latency: every output is exactly 2 cycles after the input digit it corresponds to. Throughput is 1 digit per cycle, with no bubbles between words.
- Digit counter cnt:
  - 0..WORD_DIGITS-1, increments each cycle run_i=1.
  - Wraps to 0 after WORD_DIGITS-1. The wrap starts a new word immediately if run_i stays high.
  - run_i=0 forces cnt=0.
- Per-word comparison FSM:
  - IDLE: run_i=0. Any run_i=1 digit goes to EQUAL (or DECIDED) with cnt=0 semantics.
  - EQUAL: all digits so far are identical. On a digit with a!=b, go to DECIDED and latch sw = (a>b, unsigned) XOR DESCEND.
  - DECIDED: sw frozen; further digits are ignored for the decision.
  - On the last digit (cnt==WORD_DIGITS-1), the next state is EQUAL with sw=0 if run_i stays high, otherwise IDLE. The decision made on the last digit itself still applies to that digit.
  - run_i=0 in any state goes to IDLE with sw=0, aborting the word. Digits already in the pipeline still drain; run_o tracks the delay.
- Steering: output digit k uses sw as updated including digit k.
  - sw=0: lo=A, hi=B.
  - sw=1: lo=B, hi=A.
  - Digits before the first difference are equal, so steering them is irrelevant.
- swap_o = swap_i(t-2) OR sw(including digit t-2), gated by run(t-2). It is a running flag; downstream samples it with last_o.
- last_o = (cnt==WORD_DIGITS-1 AND run_i), delayed 2.
- Equal words: sw stays 0 and pass straight through.
- run_i=0: inputs are don't-care, lo/hi outputs are 0.

Optional Feature:
CMP_SIGNED_EN
- Defined: the MSB digit (cnt==0) is compared as a two's-complement DIGIT_W value; lower digits are compared unsigned. Whole words then sort as signed.
- Undefined: all digits are compared unsigned. The logic is absent, not just disabled.

Decomposition:
- Package digit_cmp_pkg holds:
  - FSM state enum {IDLE, EQUAL, DECIDED}.
  - Function for counter width = clog2(WORD_DIGITS).
- Sub-module digit_cmp_fsm holds the counter, FSM and sw latch. Its output sw_o is combinational-plus-latched, valid for the current digit.
- The top level holds the 2-stage data, swap and run pipelines and the steering mux.

Test Plan:
1. DIGIT_W=1, WORD_DIGITS=8, A=0xA5, B=0x5A streamed from cycle 0 -> cycles 2..9: lo=0x5A, hi=0xA5; swap_o=1 cycles 2..9; last_o=1 at cycle 9 only.
2. A=B=0x3C, swap_i=0 -> lo=A, hi=B, swap_o=0 throughout; with swap_i=1 on all digits, swap_o=1 cycles 2..9.
3. Back-to-back words with run_i high 16 cycles: (A=0x81,B=0x80) then (A=0x10,B=0x11) -> word 1 swapped, word 2 passed; swap_o falls to 0 at cycle 10; last_o at cycles 9 and 17.
4. DIGIT_W=4, WORD_DIGITS=2, DESCEND=1: A=0x12, B=0x19 -> lo stream 0x1,0x9, hi stream 0x1,0x2; swap_o 0 at cycle 2, 1 at cycle 3.
5. rst=1 at cycle 4 of word A=0xF0,B=0x0F, then a new word from cycle 6 -> outputs 0 at cycles 5..7; new word is correct from cycle 8 and unaffected by the old decision. Repeat with run_i=0 at cycle 4 instead -> FSM goes IDLE and the next word is correct.
6. CMP_SIGNED_EN, DIGIT_W=4, WORD_DIGITS=2: A=0x80 (-128), B=0x7F -> lo=A, hi=B, swap_o=0; without the macro -> swapped, swap_o=1.
